// File: rtl/mem_read_streamer.sv
// rtl/mem_read_streamer.sv - streams a wrapping address range of a sync-read memory over valid/ready
// Optional MEM_READ_LAST_EN adds out_last, flagging the final word of each transfer.
module mem_read_streamer #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
`ifdef MEM_READ_LAST_EN
    output logic              out_last,
`endif
    input  logic              out_ready
);

    localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DONE} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W:0]     remaining;
    logic [ADDR_W:0]     len_clamped;
    logic                inflight;
    logic [DATA_W-1:0]   fifo_data [2];
    logic                wr_ptr, rd_ptr;
    logic [1:0]          count;
    logic [2:0]          occ;
    logic                push, pop, issue, final_pop;

`ifdef MEM_READ_LAST_EN
    logic                inflight_last;
    logic                fifo_last [2];
    assign out_last = out_valid & fifo_last[rd_ptr];
`endif

    assign out_valid   = (count != 2'd0);
    assign out_data    = fifo_data[rd_ptr];
    assign pop         = out_valid & out_ready;
    assign push        = inflight;
    assign len_clamped = (len > DEPTH_L) ? DEPTH_L : len;

    // Occupancy after this cycle's pop, counting the read still in the memory pipe.
    assign occ   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign issue = (state == S_READ) && (remaining != '0) && (occ < 3'd2);

    assign mem_re   = issue;
    assign mem_addr = addr;
    assign busy     = (state == S_READ);
    assign done     = (state == S_DONE);

    assign final_pop = pop && (remaining == '0) && !inflight && (count == 2'd1);

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (start) state_nxt = (len == '0) ? S_DONE : S_READ;
            S_READ: if (final_pop) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            addr      <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            for (int i = 0; i < 2; i++) fifo_data[i] <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            if (state == S_IDLE && start) begin
                addr      <= base_addr;
                remaining <= len_clamped;
            end else if (issue) begin
                addr      <= addr + ADDR_W'(1);
                remaining <= remaining - (ADDR_W+1)'(1);
            end
            if (push) begin
                fifo_data[wr_ptr] <= mem_rdata;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef MEM_READ_LAST_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_last <= 1'b0;
            for (int i = 0; i < 2; i++) fifo_last[i] <= 1'b0;
        end else begin
            inflight_last <= issue && (remaining == (ADDR_W+1)'(1));
            if (push) fifo_last[wr_ptr] <= inflight_last;
        end
    end
`endif

endmodule

// File: tb/tb_mem_read_streamer.sv
// tb/tb_mem_read_streamer.sv - self-checking bench for mem_read_streamer
module tb_mem_read_streamer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] base_addr = '0;
    logic [4:0] len = '0;
    logic       busy, done, mem_re, out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] mem_addr;
    logic [7:0] mem_rdata = '0;
    logic [7:0] out_data;
`ifdef MEM_READ_LAST_EN
    logic       out_last;
`endif

    mem_read_streamer #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .out_data(out_data), .out_valid(out_valid),
`ifdef MEM_READ_LAST_EN
        .out_last(out_last),
`endif
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [16];
    always @(posedge clk) mem_rdata <= mem_re ? mem[mem_addr] : 8'hEE;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [7:0] sb [$];
    logic [3:0] addr_q [$];
    int n_re, popped, done_cyc, first_valid_cyc;
    bit prev_stall = 0;
    logic [7:0] prev_data;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (mem_re) begin
                n_re++;
                addr_q.push_back(mem_addr);
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (done && done_cyc < 0) begin
                done_cyc = cyc;
                check("busy_at_done", {31'b0, busy}, 32'd0);
            end
            check("occupancy_le_2", int'(dut.count) + int'(dut.inflight) <= 2, 32'd1);
            if (prev_stall) begin
                check("stall_valid", {31'b0, out_valid}, 32'd1);
                check("stall_data", {24'b0, out_data}, {24'b0, prev_data});
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %0h expected none", out_data);
                end else begin
`ifdef MEM_READ_LAST_EN
                    check("out_last", {31'b0, out_last}, {31'b0, sb.size() == 1});
`endif
                    check("stream_byte", {24'b0, out_data}, {24'b0, sb.pop_front()});
                    popped++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    typedef struct {
        logic [3:0] base;
        logic [4:0] len;
        bit         bp;
        int         restart;
        int         exp_words;
        int         exp_done_lat;
        int         exp_first_lat;
    } vec_t;

    task automatic clear_mon();
        n_re = 0; popped = 0; done_cyc = -1; first_valid_cyc = -1;
        addr_q.delete();
    endtask

    task automatic issue_start(input logic [3:0] b, input logic [4:0] l);
        int nw;
        base_addr = b; len = l; start = 1'b1;
        nw = (l > 16) ? 16 : int'(l);
        for (int i = 0; i < nw; i++) sb.push_back(mem[(int'(b) + i) % 16]);
    endtask

    task automatic run_xfer(input vec_t v);
        int t0;
        clear_mon();
        @(posedge clk); #1;
        t0 = cyc;
        issue_start(v.base, v.len);
        for (int k = 1; k < 400; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (k == v.restart) begin
                base_addr = 4'd9; len = 5'd2; start = 1'b1;
            end
            if (v.bp) out_ready = (k >= 4 && k < 9) ? 1'b0 : 1'($urandom_range(0, 1));
            else      out_ready = 1'b1;
            if (done_cyc >= 0) break;
        end
        start = 1'b0;
        if (done_cyc < 0) check("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
        check("done_one_cycle", {31'b0, done}, 32'd0);
        out_ready = 1'b1;
        check("mem_re_count", n_re, v.exp_words);
        check("all_delivered", sb.size(), 32'd0);
        check("bytes_popped", popped, v.exp_words);
        if (v.exp_done_lat >= 0) check("done_latency", done_cyc - t0, v.exp_done_lat);
        if (v.exp_first_lat >= 0) check("first_valid_latency", first_valid_cyc - t0, v.exp_first_lat);
        check("addr_seq_len", addr_q.size(), v.exp_words);
        for (int i = 0; i < addr_q.size(); i++)
            check("addr_seq", {28'b0, addr_q[i]}, (int'(v.base) + i) % 16);
        sb.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_done"}, {31'b0, done}, 32'd0);
        check({tag, "_mem_re"}, {31'b0, mem_re}, 32'd0);
        check({tag, "_mem_addr"}, {28'b0, mem_addr}, 32'd0);
        check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        check({tag, "_out_data"}, {24'b0, out_data}, 32'd0);
    endtask

    vec_t tbl [6];

    initial begin
        for (int k = 0; k < 16; k++) mem[(3 + k) % 16] = 8'hA0 + 8'(k);
        //          base   len    bp  restart words done first
        tbl[0] = '{4'd3,  5'd4,  0, 0, 4,  7,  3};
        tbl[1] = '{4'd14, 5'd4,  0, 0, 4,  7,  3};
        tbl[2] = '{4'd0,  5'd16, 1, 0, 16, -1, -1};
        tbl[3] = '{4'd5,  5'd0,  0, 0, 0,  1,  -1};
        tbl[4] = '{4'd7,  5'd20, 0, 0, 16, 19, 3};
        tbl[5] = '{4'd3,  5'd4,  0, 2, 4,  7,  3};

        clear_mon();
        #2 rst = 1'b1;
        #1 check_outputs_zero("reset");
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 6; i++) run_xfer(tbl[i]);

        // Reset in the middle of a len=8 stream, then a fresh short transfer.
        clear_mon();
        @(posedge clk); #1;
        issue_start(4'd0, 5'd8);
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (popped >= 2) break;
        end
        check("popped_before_reset", popped, 32'd2);
        #2 rst = 1'b1;
        #1 check_outputs_zero("midreset");
        sb.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_reset_valid", {31'b0, out_valid}, 32'd0);
        check("post_reset_busy", {31'b0, busy}, 32'd0);
        run_xfer('{4'd0, 5'd2, 0, 0, 2, 5, 3});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
